cs_resolve: RTL and testbench
=============================

# cs_resolve

Post-stage for the OM-Pipe multiplier. Consumes the carry-save pair (p, q) and modulus r from the last pipeline stage. Resolves p+q with a chunked carry-propagate adder and applies one conditional subtraction of r, emitting the fully reduced N-bit product. Carry chains are chunked W bits per cycle so the block never limits the pipeline clock.

## Interface
- N, default 512: operand/modulus width; p, q are N+1 bits.
- W, default 64: chunk width per cycle; must divide into CW = C·W ≥ N+2, with C = ceil((N+2)/W).
- KW, default $clog2(N)+1: width of the k tag.

- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  upstream done; p, q, r, k valid.
- in_ready  out  1  high only in IDLE.
- p  in  N+1  carry-save sum word.
- q  in  N+1  carry-save carry word.
- r  in  N  modulus.
- k  in  KW  tag, passed through unchanged.
- out_valid  out  1  result valid, held until accepted.
- out_ready  in  1  downstream accept.
- res  out  N  (p+q) mod r.
- out_k  out  KW  tag captured with the operands.

## Operation
- Precondition: p+q < 2r. Result is then s if s < r, else s−r, where s = p+q.
- States:
  - IDLE: in_ready=1. On in_valid, latch p, q, r (zero-extended to CW) and k, clear chunk index, add-carry and sub-borrow, then go to ADD.
  - ADD: one chunk per cycle, LSB first. For chunk i:
    - s_i = p_i + q_i + carry.
    - d_i = s_i − r_i − borrow.
    - Store s_i and d_i in shift registers; update carry and borrow.
  - ADD exit: on chunk C−1, register res = (final borrow==0) ? d[N-1:0] : s[N-1:0], then go to OUT.
  - OUT: out_valid=1, res and out_k held stable. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE; upstream must hold its data until accepted.
- Final carry out of the add is always 0 under the precondition and is not used.

## Timing
- Reset values: in_ready=1, out_valid=0, res=0, out_k=0, state=IDLE, all internal registers 0.
- Latency: out_valid rises C cycles after the accept edge.
- Minimum accept-to-accept interval is C+2 cycles, with out_ready held high.
- out_ready is sampled only in OUT. A simultaneous in_valid in OUT is not accepted (in_ready=0).
- No combinational path from in_valid or out_ready to any output except through state.
- Reset in any state aborts the operation and discards it; no out_valid for the aborted operation.
- s exactly equal to r gives borrow 0, so res = 0.

## Configuration
- CS_RESOLVE_RANGE_CHECK_EN
  - Defined: adds output `range_err` (1 bit), registered with res. It is 1 when the selected result is still ≥ r, i.e. the precondition was violated; it is computed with a second chunk-parallel compare of d against r during ADD. range_err resets to 0 and holds with res in OUT.
  - Undefined: no port and no compare logic; the result is unspecified if the precondition is violated.

## Structure
- Package cs_resolve_pkg holds:
  - the state enum (IDLE, ADD, OUT);
  - the function for C;
  - the localparam CW.
- Sub-module cs_chunk_addsub: combinational W-bit slice. Inputs p_i, q_i, r_i, carry_in, borrow_in. Outputs s_i, d_i, carry_out, borrow_out. Instantiated once and reused across cycles.

## Test plan
- Bench config: N=16, W=4, so C=5.
- Reset then idle: in_ready=1, out_valid=0, res=0 after a reset pulse.
- p=0x0100, q=0x0023, r=0x1000, k=7 → s=0x0123 < r, res=0x0123, out_k=7. out_valid rises 5 cycles after accept.
- p=0x0F00, q=0x0200, r=0x1000 → s=0x1100 ≥ r, res=0x0100.
- Boundary s=r: p=0x8000, q=0x7FFF, r=0xFFFF → res=0x0000.
- Carry across all chunks: p=0x0FFFF, q=0x00001, r=0xFFFF → s=0x10000, res=0x0001.
- Backpressure: hold out_ready=0 for 10 cycles, then 1. res is stable throughout, in_valid pulses meanwhile are ignored, and the next accept comes 2 cycles after the handshake.
- Reset mid-ADD (cycle 2) → no out_valid, in_ready=1 on the next cycle.
- With CS_RESOLVE_RANGE_CHECK_EN: p=0x1FFFF, q=0x1FFFF, r=0x0010 → range_err=1.

Source files
------------

// File: rtl/cs_resolve_pkg.sv
// Shared types and sizing helpers for the cs_resolve carry-save post-stage.
package cs_resolve_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    OUT  = 2'd2
  } state_e;

  // Number of W-bit chunks needed to cover the N+2 bit extended operands.
  function automatic int unsigned chunk_count(input int unsigned n, input int unsigned w);
    return (n + 2 + w - 1) / w;
  endfunction

  localparam int unsigned DEF_N = 512;
  localparam int unsigned DEF_W = 64;
  localparam int unsigned CW    = chunk_count(DEF_N, DEF_W) * DEF_W;

endpackage

// File: rtl/cs_resolve_if.sv
// Operand/result handshake bundle for cs_resolve.
// range_err exists only when CS_RESOLVE_RANGE_CHECK_EN is defined.
interface cs_resolve_if #(
  parameter int unsigned N  = 512,
  parameter int unsigned KW = $clog2(N) + 1
);
  logic          in_valid;
  logic          in_ready;
  logic [N:0]    p;
  logic [N:0]    q;
  logic [N-1:0]  r;
  logic [KW-1:0] k;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  res;
  logic [KW-1:0] out_k;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
  logic          range_err;

  modport master (output in_valid, p, q, r, k, out_ready,
                  input  in_ready, out_valid, res, out_k, range_err);
  modport slave  (input  in_valid, p, q, r, k, out_ready,
                  output in_ready, out_valid, res, out_k, range_err);
`else
  modport master (output in_valid, p, q, r, k, out_ready,
                  input  in_ready, out_valid, res, out_k);
  modport slave  (input  in_valid, p, q, r, k, out_ready,
                  output in_ready, out_valid, res, out_k);
`endif
endinterface

// File: rtl/cs_chunk_addsub.sv
// One W-bit slice: adds p+q+carry, then subtracts r+borrow from that sum.
module cs_chunk_addsub #(
  parameter int unsigned W = 64
) (
  input  logic [W-1:0] p_i,
  input  logic [W-1:0] q_i,
  input  logic [W-1:0] r_i,
  input  logic         carry_in,
  input  logic         borrow_in,
  output logic [W-1:0] s_i,
  output logic [W-1:0] d_i,
  output logic         carry_out,
  output logic         borrow_out
);

  logic [W:0] sum;
  logic [W:0] dif;

  // The top bit of dif goes high exactly when s_i < r_i + borrow_in.
  always_comb begin
    sum        = {1'b0, p_i} + {1'b0, q_i} + (W+1)'(carry_in);
    dif        = {1'b0, sum[W-1:0]} - {1'b0, r_i} - (W+1)'(borrow_in);
    s_i        = sum[W-1:0];
    carry_out  = sum[W];
    d_i        = dif[W-1:0];
    borrow_out = dif[W];
  end

endmodule

// File: rtl/cs_resolve.sv
// Resolves a carry-save pair p+q chunk-serially and reduces it once by r.
// Define CS_RESOLVE_RANGE_CHECK_EN to add the range_err output.
module cs_resolve
  import cs_resolve_pkg::*;
#(
  parameter int unsigned N  = 512,
  parameter int unsigned W  = 64,
  parameter int unsigned KW = $clog2(N) + 1
) (
  input logic         clock,
  input logic         reset,
  cs_resolve_if.slave bus
);

  localparam int unsigned C   = chunk_count(N, W);
  localparam int unsigned XW  = C * W;
  localparam int unsigned IW  = $clog2(C + 1);
  localparam int unsigned NBW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned WBW = (W > 1) ? $clog2(W) : 1;

  state_e        state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic [N-1:0]  res_q, res_d;
  logic [KW-1:0] out_k_q, out_k_d;
  logic [XW-1:0] p_q, p_d, q_q, q_d, r_q, r_d;
  logic [N-1:0]  s_acc_q, s_acc_d, d_acc_q, d_acc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          carry_q, carry_d, borrow_q, borrow_d;

  logic [W-1:0]  s_i, d_i;
  logic          carry_o, borrow_o;

  cs_chunk_addsub #(.W(W)) u_chunk (
    .p_i        (p_q[W-1:0]),
    .q_i        (q_q[W-1:0]),
    .r_i        (r_q[W-1:0]),
    .carry_in   (carry_q),
    .borrow_in  (borrow_q),
    .s_i        (s_i),
    .d_i        (d_i),
    .carry_out  (carry_o),
    .borrow_out (borrow_o)
  );

`ifdef CS_RESOLVE_RANGE_CHECK_EN
  logic cmp_borrow_q, cmp_borrow_d, cmp_borrow_o;
  logic range_err_q, range_err_d;

  // Running compare of d against r; final no-borrow means d >= r.
  assign cmp_borrow_o = (d_i < r_q[W-1:0]) || ((d_i == r_q[W-1:0]) && cmp_borrow_q);
`endif

  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    res_d       = res_q;
    out_k_d     = out_k_q;
    p_d         = p_q;
    q_d         = q_q;
    r_d         = r_q;
    s_acc_d     = s_acc_q;
    d_acc_d     = d_acc_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    borrow_d    = borrow_q;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
    cmp_borrow_d = cmp_borrow_q;
    range_err_d  = range_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d    = ADD;
          in_ready_d = 1'b0;
          p_d        = XW'(bus.p);
          q_d        = XW'(bus.q);
          r_d        = XW'(bus.r);
          out_k_d    = bus.k;
          idx_d      = '0;
          carry_d    = 1'b0;
          borrow_d   = 1'b0;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
          cmp_borrow_d = 1'b0;
`endif
        end
      end

      ADD: begin
        p_d      = p_q >> W;
        q_d      = q_q >> W;
        r_d      = r_q >> W;
        carry_d  = carry_o;
        borrow_d = borrow_o;
        idx_d    = idx_q + IW'(1);
`ifdef CS_RESOLVE_RANGE_CHECK_EN
        cmp_borrow_d = cmp_borrow_o;
`endif
        // Drop the current chunk into its slot; bits at or above N are discarded.
        for (int unsigned b = 0; b < N; b++) begin
          if (idx_q == IW'(b / W)) begin
            s_acc_d[NBW'(b)] = s_i[WBW'(b % W)];
            d_acc_d[NBW'(b)] = d_i[WBW'(b % W)];
          end
        end
        if (idx_q == IW'(C - 1)) begin
          state_d     = OUT;
          out_valid_d = 1'b1;
          res_d       = borrow_o ? s_acc_d : d_acc_d;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
          range_err_d = !borrow_o && !cmp_borrow_o;
`endif
        end
      end

      OUT: begin
        if (bus.out_ready) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      res_q       <= '0;
      out_k_q     <= '0;
      p_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      s_acc_q     <= '0;
      d_acc_q     <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      borrow_q    <= 1'b0;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
      cmp_borrow_q <= 1'b0;
      range_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      res_q       <= res_d;
      out_k_q     <= out_k_d;
      p_q         <= p_d;
      q_q         <= q_d;
      r_q         <= r_d;
      s_acc_q     <= s_acc_d;
      d_acc_q     <= d_acc_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      borrow_q    <= borrow_d;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
      cmp_borrow_q <= cmp_borrow_d;
      range_err_q  <= range_err_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.res       = res_q;
  assign bus.out_k     = out_k_q;
`ifdef CS_RESOLVE_RANGE_CHECK_EN
  assign bus.range_err = range_err_q;
`endif

endmodule

// File: tb/tb_cs_resolve.sv
// Directed bench for cs_resolve at N=16, W=4 (five chunks).
// Range-error vectors run only when CS_RESOLVE_RANGE_CHECK_EN is defined.
module tb_cs_resolve;

  localparam int unsigned N  = 16;
  localparam int unsigned W  = 4;
  localparam int unsigned KW = 5;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_errs   = 0;

  cs_resolve_if #(.N(N), .KW(KW)) bus ();

  cs_resolve #(.N(N), .W(W), .KW(KW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errs++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic start_op(input logic [N:0] p, input logic [N:0] q,
                          input logic [N-1:0] r, input logic [KW-1:0] k);
    bit ok;
    ok           = 1'b0;
    bus.in_valid = 1'b1;
    bus.p        = p;
    bus.q        = q;
    bus.r        = r;
    bus.k        = k;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = (bus.in_ready === 1'b1);
      step();
    end
    bus.in_valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic finish_op(input logic [N-1:0] exp_res, input logic [KW-1:0] exp_k,
                           input string tag);
    int n;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, 32'(n), 32'd5);
    chk({tag, "_res"}, 32'(bus.res), 32'(exp_res));
    chk({tag, "_out_k"}, 32'(bus.out_k), 32'(exp_k));
  endtask

  task automatic handshake(input string tag);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bit seen;
    bus.in_valid  = 1'b0;
    bus.p         = '0;
    bus.q         = '0;
    bus.r         = '0;
    bus.k         = '0;
    bus.out_ready = 1'b0;
    reset         = 1'b1;
    repeat (3) step();
    reset = 1'b0;

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_res", 32'(bus.res), 32'd0);
    chk("rst_out_k", 32'(bus.out_k), 32'd0);
`ifdef CS_RESOLVE_RANGE_CHECK_EN
    chk("rst_range_err", 32'(bus.range_err), 32'd0);
`endif

    // s below r: passthrough of the sum
    start_op(17'h00100, 17'h00023, 16'h1000, 5'd7);
    chk("busy_in_ready", 32'(bus.in_ready), 32'd0);
    finish_op(16'h0123, 5'd7, "op1");
`ifdef CS_RESOLVE_RANGE_CHECK_EN
    chk("op1_range_err", 32'(bus.range_err), 32'd0);
`endif
    handshake("op1");

    // s above r: one subtraction
    start_op(17'h00F00, 17'h00200, 16'h1000, 5'd2);
    finish_op(16'h0100, 5'd2, "op2");
    handshake("op2");

    // s exactly r gives zero
    start_op(17'h08000, 17'h07FFF, 16'hFFFF, 5'd4);
    finish_op(16'h0000, 5'd4, "op3");
    handshake("op3");

    // carry ripples through every chunk
    start_op(17'h0FFFF, 17'h00001, 16'hFFFF, 5'd5);
    finish_op(16'h0001, 5'd5, "op4");
    handshake("op4");

    // backpressure: hold the result with stray in_valid pulses
    start_op(17'h00005, 17'h00003, 16'h0100, 5'd3);
    finish_op(16'h0008, 5'd3, "bp");
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.p        = 17'h1234;
      bus.q        = 17'h0111;
      bus.r        = 16'h2000;
      bus.k        = 5'd30;
      step();
      chk("bp_hold_res", 32'(bus.res), 32'h0008);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    chk("bp_hold_out_k", 32'(bus.out_k), 32'd3);
    bus.in_valid  = 1'b1;
    bus.p         = 17'h00010;
    bus.q         = 17'h00020;
    bus.r         = 16'h0040;
    bus.k         = 5'd9;
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    chk("bp_next_accept", 32'(bus.in_ready), 32'd0);
    finish_op(16'h0030, 5'd9, "bp_next");
    handshake("bp_next");

    // reset two cycles into ADD discards the operation
    start_op(17'h00F00, 17'h00200, 16'h1000, 5'd6);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.out_valid === 1'b1) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    chk("abort_res_cleared", 32'(bus.res), 32'd0);

    // normal operation resumes after the abort
    start_op(17'h00100, 17'h00023, 16'h1000, 5'd11);
    finish_op(16'h0123, 5'd11, "post_abort");
    handshake("post_abort");

`ifdef CS_RESOLVE_RANGE_CHECK_EN
    // precondition violated: d = 0x3FFEE is still >= r
    start_op(17'h1FFFF, 17'h1FFFF, 16'h0010, 5'd1);
    finish_op(16'hFFEE, 5'd1, "rng");
    chk("rng_range_err", 32'(bus.range_err), 32'd1);
    handshake("rng");
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
